// File: rtl/vga_pkg.sv
// vga_pkg -- shared VGA 640x480@60 timing constants and the 16-entry
// 12-bit palette used by vga_compositor and palette_lut.
// Timing: H_* / V_* are counter values; *_SYNC_END is exclusive.
// No ports (package).
package vga_pkg;

  localparam logic [9:0] H_ACTIVE     = 10'd640;
  localparam logic [9:0] H_SYNC_START = 10'd656;
  localparam logic [9:0] H_SYNC_END   = 10'd752;
  localparam logic [9:0] H_TOTAL      = 10'd800;
  localparam logic [9:0] H_LAST       = H_TOTAL - 10'd1;

  localparam logic [9:0] V_ACTIVE     = 10'd480;
  localparam logic [9:0] V_SYNC_START = 10'd490;
  localparam logic [9:0] V_SYNC_END   = 10'd492;
  localparam logic [9:0] V_TOTAL      = 10'd525;
  localparam logic [9:0] V_LAST       = V_TOTAL - 10'd1;

  typedef logic [11:0] rgb_t;

  // Classic 16-colour EGA-style palette, {R,G,B} nibbles.
  localparam rgb_t PALETTE [16] = '{
    12'h000, 12'h00A, 12'h0A0, 12'h0AA,
    12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
    12'h555, 12'h55F, 12'h5F5, 12'h5FF,
    12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
  };

endpackage

// File: rtl/vga_compositor_palette_lut.sv
// palette_lut -- registered palette lookup.
// Ports:
//   clk   : pixel clock
//   rst   : asynchronous active-high reset, clears rgb
//   index : 4-bit palette index
//   blank : forces the registered colour to black (outside active video)
//   rgb   : registered 12-bit {R,G,B} colour, one cycle after index
module palette_lut
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  index,
  input  logic        blank,
  output logic [11:0] rgb
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb <= '0;
    end else if (blank) begin
      rgb <= '0;
    end else begin
      rgb <= PALETTE[index];
    end
  end

endmodule

// File: rtl/vga_compositor.sv
// vga_compositor -- 640x480 VGA timing generator and sprite-layer compositor.
// Generates the raster counters, broadcasts the 160x120 canvas position
// (x,y) to external 1-cycle-registered sprite modules, picks the lowest
// valid layer (else BG_INDEX), looks it up in the palette and emits
// registered RGB with hsync/vsync aligned 3 cycles after the counters.
// Ports:
//   clk, rst            : pixel clock, asynchronous active-high reset
//   x, y                : canvas column/row (counters >> 2)
//   layerIndex          : packed 4-bit palette index per layer
//   layerValid          : per-layer opaque flag
//   red, green, blue    : 4-bit colour channels
//   hsync, vsync        : active-low sync
//   frameStart          : one-cycle pulse when counters wrap to (0,0)
// Optional build macro: SCANLINE_DIM_EN halves the colour on odd lines.
module vga_compositor
  import vga_pkg::*;
#(
  parameter int         NUM_LAYERS = 4,
  parameter logic [3:0] BG_INDEX   = 4'd0
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [9:0]              x,
  output logic [9:0]              y,
  input  logic [4*NUM_LAYERS-1:0] layerIndex,
  input  logic [NUM_LAYERS-1:0]   layerValid,
  output logic [3:0]              red,
  output logic [3:0]              green,
  output logic [3:0]              blue,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    frameStart
);

  logic [9:0] h_count_reg;
  logic [9:0] v_count_reg;
  logic       frame_start_reg;
  logic       h_wrap;
  logic       v_wrap;

  assign h_wrap = (h_count_reg == H_LAST);
  assign v_wrap = (v_count_reg == V_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_count_reg     <= '0;
      v_count_reg     <= '0;
      frame_start_reg <= 1'b0;
    end else begin
      h_count_reg     <= h_wrap ? 10'd0 : h_count_reg + 10'd1;
      if (h_wrap) begin
        v_count_reg <= v_wrap ? 10'd0 : v_count_reg + 10'd1;
      end
      // Registered so the pulse lands on the cycle the counters read (0,0).
      frame_start_reg <= h_wrap && v_wrap;
    end
  end

  assign x          = {2'b00, h_count_reg[9:2]};
  assign y          = {2'b00, v_count_reg[9:2]};
  assign frameStart = frame_start_reg;

  // Stage 0 flags decoded straight from the counters. Sync flags are kept
  // active-high inside the pipeline so a cleared pipeline means "no sync".
  logic act_s0;
  logic hs_s0;
  logic vs_s0;

  assign act_s0 = (h_count_reg < H_ACTIVE) && (v_count_reg < V_ACTIVE);
  assign hs_s0  = (h_count_reg >= H_SYNC_START) && (h_count_reg < H_SYNC_END);
  assign vs_s0  = (v_count_reg >= V_SYNC_START) && (v_count_reg < V_SYNC_END);

  // Stage 1 lines up with the sprite modules' registered outputs.
  logic act_d1_reg, hs_d1_reg, vs_d1_reg;
  // Stage 2 holds the selected index.
  logic act_d2_reg, hs_d2_reg, vs_d2_reg;
  logic [3:0] sel_index_reg;
  logic [3:0] sel_index_next;
  // Stage 3 is the output register set.
  logic hsync_reg, vsync_reg;

  logic [3:0] layer_idx [NUM_LAYERS];

  for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_unpack
    assign layer_idx[gi] = layerIndex[4*gi +: 4];
  end

  // Lowest-numbered valid layer wins; the descending scan lets the lowest
  // k overwrite any higher one. Off-canvas positions fall back to BG_INDEX
  // and are blanked further down anyway.
  always_comb begin
    sel_index_next = BG_INDEX;
    if (act_d1_reg) begin
      for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
        if (layerValid[k]) begin
          sel_index_next = layer_idx[k];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_d1_reg    <= 1'b0;
      hs_d1_reg     <= 1'b0;
      vs_d1_reg     <= 1'b0;
      act_d2_reg    <= 1'b0;
      hs_d2_reg     <= 1'b0;
      vs_d2_reg     <= 1'b0;
      sel_index_reg <= '0;
      hsync_reg     <= 1'b1;
      vsync_reg     <= 1'b1;
    end else begin
      act_d1_reg    <= act_s0;
      hs_d1_reg     <= hs_s0;
      vs_d1_reg     <= vs_s0;
      act_d2_reg    <= act_d1_reg;
      hs_d2_reg     <= hs_d1_reg;
      vs_d2_reg     <= vs_d1_reg;
      sel_index_reg <= sel_index_next;
      hsync_reg     <= ~hs_d2_reg;
      vsync_reg     <= ~vs_d2_reg;
    end
  end

  assign hsync = hsync_reg;
  assign vsync = vsync_reg;

  logic [11:0] rgb_reg;

  palette_lut u_palette (
    .clk   (clk),
    .rst   (rst),
    .index (sel_index_reg),
    .blank (~act_d2_reg),
    .rgb   (rgb_reg)
  );

`ifdef SCANLINE_DIM_EN
  // Line parity travels with the pixel so dimming matches the output row.
  logic vodd_d1_reg, vodd_d2_reg, vodd_d3_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vodd_d1_reg <= 1'b0;
      vodd_d2_reg <= 1'b0;
      vodd_d3_reg <= 1'b0;
    end else begin
      vodd_d1_reg <= v_count_reg[0];
      vodd_d2_reg <= vodd_d1_reg;
      vodd_d3_reg <= vodd_d2_reg;
    end
  end

  assign red   = vodd_d3_reg ? {1'b0, rgb_reg[11:9]} : rgb_reg[11:8];
  assign green = vodd_d3_reg ? {1'b0, rgb_reg[7:5]}  : rgb_reg[7:4];
  assign blue  = vodd_d3_reg ? {1'b0, rgb_reg[3:1]}  : rgb_reg[3:0];
`else
  assign red   = rgb_reg[11:8];
  assign green = rgb_reg[7:4];
  assign blue  = rgb_reg[3:0];
`endif

endmodule

// File: tb/tb_vga_compositor.sv
// tb_vga_compositor -- randomized bench for vga_compositor with a
// cycle-indexed reference model and a few hand-computed spot checks.
// Honours SCANLINE_DIM_EN when compiled with the same define as the RTL.
module tb_vga_compositor;

  localparam int         NL = 4;
  localparam logic [3:0] BG = 4'd0;

  localparam logic [11:0] PAL [16] = '{
    12'h000, 12'h00A, 12'h0A0, 12'h0AA,
    12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
    12'h555, 12'h55F, 12'h5F5, 12'h5FF,
    12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
  };

  logic          clk;
  logic          rst;
  logic [9:0]    x, y;
  logic [4*NL-1:0] layerIndex;
  logic [NL-1:0] layerValid;
  logic [3:0]    red, green, blue;
  logic          hsync, vsync, frameStart;

  vga_compositor #(.NUM_LAYERS(NL), .BG_INDEX(BG)) dut (
    .clk        (clk),
    .rst        (rst),
    .x          (x),
    .y          (y),
    .layerIndex (layerIndex),
    .layerValid (layerValid),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .hsync      (hsync),
    .vsync      (vsync),
    .frameStart (frameStart)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n = 0;          // cycles since the last reset release
  bit in_rst = 1'b1;
  bit running = 1'b0;
  int hs_low_cnt = 0;

  logic [15:0] hist_idx [4];
  logic [3:0]  hist_val [4];

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, n, act, exp);
    end
  endtask

  task automatic spot(input string name, input int unsigned act, input int unsigned exp);
    $display("spot %s cycle %0d got %0h want %0h", name, n, act, exp);
    chk(name, act, exp);
  endtask

  // Layer data driven in cycle nn belongs to the counter value of nn-1.
  task automatic drive(input int nn);
    int c, hc, vc;
    logic [15:0] li;
    logic [3:0]  lv;
    li = 16'($urandom);
    lv = 4'($urandom & $urandom);
    c = nn - 1;
    if (c >= 0) begin
      hc = c % 800;
      vc = (c / 800) % 525;
      if (vc == 0 && hc >= 600 && hc < 640) begin
        li = 16'hFFFF; lv = 4'b0001;
      end else if (vc == 0 && hc >= 640) begin
        lv = 4'hF;
      end else if (vc == 1 && hc < 320) begin
        lv = 4'h0;
      end else if (vc == 1 && hc < 640) begin
        li = 16'h000F; lv = 4'b0001;
      end else if (vc == 2) begin
        li[11:4] = 8'h53; lv = 4'b0110;
      end
    end
    layerIndex = li;
    layerValid = lv;
    hist_idx[nn % 4] = li;
    hist_val[nn % 4] = lv;
  endtask

  task automatic spot_checks(input int nn);
    logic [11:0] rgb;
    rgb = {red, green, blue};
    if (hsync == 1'b0 && nn < 1000) hs_low_cnt++;
    if (nn == 658) spot("hsync_before_fall", hsync, 1);
    if (nn == 659) spot("hsync_fall", hsync, 0);
    if (nn == 999) spot("hsync_low_len", hs_low_cnt, 96);
    if (nn == 3 + 610) spot("line0_full", rgb, 12'hFFF);
    if (nn == 3 + 703) begin
      spot("blank_700_rgb", rgb, 12'h000);
      spot("blank_700_hsync", hsync, 0);
    end
    if (nn == 3 + 800 + 100) spot("background", rgb, 12'h000);
`ifdef SCANLINE_DIM_EN
    if (nn == 3 + 800 + 400) spot("line1_dim", rgb, 12'h777);
`else
    if (nn == 3 + 800 + 400) spot("line1_full", rgb, 12'hFFF);
`endif
    if (nn == 3 + 1600 + 100) spot("priority", rgb, 12'h0AA);
  endtask

  // Reference model: what the outputs must be in cycle m after release.
  int m, hm, vm, c, hc, vc;
  bit act;
  logic [11:0] col;
  logic [3:0]  val, idx;
  logic [15:0] lidx;

  always @(negedge clk) begin
    if (running) begin
      if (in_rst) begin
        chk("rst_rgb", {red, green, blue}, 0);
        chk("rst_hsync", hsync, 1);
        chk("rst_vsync", vsync, 1);
        chk("rst_frame", frameStart, 0);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
      end else begin
        m  = n;
        hm = m % 800;
        vm = (m / 800) % 525;
        chk("x", x, hm / 4);
        chk("y", y, vm / 4);
        chk("frameStart", frameStart, (m > 0 && m % 420000 == 0) ? 1 : 0);
        if (m < 3) begin
          chk("rgb", {red, green, blue}, 0);
          chk("hsync", hsync, 1);
          chk("vsync", vsync, 1);
        end else begin
          c  = m - 3;
          hc = c % 800;
          vc = (c / 800) % 525;
          act = (hc < 640) && (vc < 480);
          col = 12'h000;
          if (act) begin
            val  = hist_val[(m - 2) % 4];
            lidx = hist_idx[(m - 2) % 4];
            idx  = BG;
            for (int k = NL - 1; k >= 0; k--) begin
              if (val[k]) idx = lidx[4*k +: 4];
            end
            col = PAL[idx];
`ifdef SCANLINE_DIM_EN
            if (vc % 2 == 1) col = (col >> 1) & 12'h777;
`endif
          end
          chk("rgb", {red, green, blue}, col);
          chk("hsync", hsync, (hc >= 656 && hc < 752) ? 0 : 1);
          chk("vsync", vsync, (vc >= 490 && vc < 492) ? 0 : 1);
        end
      end
    end
  end

  task automatic release_rst();
    rst = 1'b0;
    in_rst = 1'b0;
    n = 0;
    hs_low_cnt = 0;
    drive(0);
    spot_checks(0);
  endtask

  task automatic run_cycles(input int count);
    for (int i = 0; i < count; i++) begin
      @(posedge clk);
      #1;
      n++;
      drive(n);
      spot_checks(n);
    end
  endtask

  initial begin
    rst = 1'b0;
    layerIndex = '0;
    layerValid = '0;
    #5;
    rst = 1'b1;
    #1;
    running = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    release_rst();
    run_cycles(30000 + int'($urandom_range(0, 799)));

    // Mid-frame reset with live layer traffic.
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1 + i);
      @(posedge clk);
      #1;
    end
    release_rst();
    run_cycles(12000);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_compositor.md
VGA_COMPOSITOR -- requirements
Module: vga_compositor

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 4, number of sprite layers composited.
REQ-002 SHALL have parameter BG_INDEX, default 4'd0, palette index used where no layer is valid.
REQ-003 SHALL have port clk, input, 1, the single clock; it is the 25.175 MHz pixel clock.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-005 SHALL have port x, output, 10, canvas column broadcast to all sprite modules.
REQ-006 SHALL have port y, output, 10, canvas row broadcast to all sprite modules.
REQ-007 SHALL have port layerIndex, input, 4*NUM_LAYERS, packed sprite palette indices; layer k occupies bits [4k+3:4k].
REQ-008 SHALL have port layerValid, input, NUM_LAYERS, per-layer opaque flag.
REQ-009 SHALL have ports red, green and blue, output, 4 each, registered colour.
REQ-010 SHALL have ports hsync and vsync, output, 1 each, registered sync signals, active-low.
REQ-011 SHALL have port frameStart, output, 1, one-cycle pulse at the start of each frame.

Function
REQ-012 SHALL run hCount over 0..799, incrementing by 1 every clk and wrapping 799->0.
REQ-013 SHALL run vCount over 0..524, incrementing when hCount wraps, wrapping 524->0.
REQ-014 SHALL drive x = hCount>>2 and y = vCount>>2, taken directly from the counter registers (160x120 canvas, x4 scaling).
REQ-015 SHALL treat sprite modules as 1-cycle registered: layerIndex/layerValid for counter value C are sampled one edge after C is presented.
REQ-016 SHALL register the selected index at the edge after REQ-015; selection is the lowest k with layerValid[k]=1, else BG_INDEX.
REQ-017 SHALL register the palette-looked-up RGB at the next edge; total latency from counter value to RGB is 3 cycles.
REQ-018 SHALL delay the active-video flag, hsync and vsync through the same 3 stages so that all outputs align.
REQ-019 SHALL assert active video only for hCount<640 and vCount<480; outside active video, RGB SHALL be 0 regardless of layers.
REQ-020 SHALL drive hsync low for hCount 656..751 and vsync low for vCount 490..491.
REQ-021 SHALL pulse frameStart for one cycle at the edge where the counters wrap from (799,524) to (0,0); the pulse is undelayed and coincides with x=0, y=0.
REQ-022 SHALL ignore layers entirely when x>=160 or y>=120, since that region is blanked.

Reset
REQ-023 SHALL, on rst, asynchronously clear hCount, vCount and all pipeline registers to 0.
REQ-024 SHALL, on rst, set hsync=1, vsync=1, red/green/blue=0 and frameStart=0.
REQ-025 SHALL, on rst released mid-frame, restart at (0,0) with the first valid RGB 3 cycles later; a stale pipeline SHALL never reach the outputs.

Configuration
REQ-026 SHALL, with SCANLINE_DIM_EN defined, output each channel shifted right by 1 on odd vCount active lines (computed in the delayed domain).
REQ-027 SHALL, without SCANLINE_DIM_EN defined, output full-intensity colour on all lines and contain no extra logic.

Structure
REQ-028 SHALL take the timing constants (H_ACTIVE, H_SYNC_START, H_SYNC_END, H_TOTAL and the V equivalents) and the 16-entry 12-bit palette table from shared package vga_pkg.
REQ-029 SHALL implement the palette lookup as sub-module palette_lut (4-bit index in, registered 12-bit RGB out).

Verification
REQ-030 SHALL verify reset release by counting cycles: hsync falls exactly 656+3 cycles after reset release, and frameStart next pulses after 420000 cycles.
REQ-031 SHALL verify priority: layerValid=4'b0110 with layer1 index 3 and layer2 index 5 -> RGB equals palette[3], 3 cycles after the matching counter value.
REQ-032 SHALL verify background: layerValid=0 and BG_INDEX=0 -> RGB equals palette[0] throughout active video.
REQ-033 SHALL verify blanking: all layers valid at hCount=700 -> RGB=0, and hsync=0 throughout 659..754 in output time.
REQ-034 SHALL verify the vertical boundary: vsync low for exactly 2 lines (1600 cycles) per frame, and y=119 on vCount 476..479.
REQ-035 SHALL verify SCANLINE_DIM_EN: palette entry 12'hFFF on line 1 -> 12'h777, and on line 0 -> 12'hFFF.
